run_monitor: RTL and testbench
==============================

RUN_MONITOR -- requirements
Module: run_monitor

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of instruction and dump data words.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, width of dump word index.
REQ-003 SHALL have parameter CNT_WIDTH, default 32, width of cycle counter.
REQ-004 SHALL have parameter HALT_INST, default 32'h0, instruction word that marks program completion.
REQ-005 SHALL have parameter DRAIN_CYCLES, default 5, pipeline drain cycles after halt or timeout (range 0..255).
REQ-006 SHALL have parameter TIMEOUT_CYCLES, default 1000000, cycle limit before forced stop.
REQ-007 SHALL have parameter DUMP_WORDS, default 20, number of words dumped (range 1..2^ADDR_WIDTH).
REQ-008 SHALL have ports: clk input 1 system clock; reset input 1 synchronous active-high reset.
REQ-009 SHALL have ports: inst_valid input 1 fetch qualifier; inst_from_imem input DATA_WIDTH fetched instruction.
REQ-010 SHALL have ports: dump_rd_en output 1 read strobe; dump_addr output ADDR_WIDTH word index; dump_rd_data input DATA_WIDTH read data, valid exactly one cycle after dump_rd_en.
REQ-011 SHALL have ports: out_valid output 1; out_ready input 1; out_index output ADDR_WIDTH; out_data output DATA_WIDTH (dump stream).
REQ-012 SHALL have ports: cycle_count output CNT_WIDTH; running output 1; done output 1; timed_out output 1.

Function
REQ-013 SHALL implement FSM states RUN, DRAIN, DUMP_RD, DUMP_WAIT, DUMP_OUT, FINISH; reset state RUN.
REQ-014 SHALL increment cycle_count by 1 every RUN cycle in which no stop condition is detected, saturating at all-ones.
REQ-015 SHALL detect halt when in RUN with inst_valid=1 and inst_from_imem==HALT_INST; cycle_count is not incremented that cycle and is frozen thereafter; next state DRAIN.
REQ-016 SHALL detect timeout when in RUN with cycle_count==TIMEOUT_CYCLES and no halt; sets timed_out=1 (sticky until reset); next state DRAIN.
REQ-017 SHALL give halt priority over timeout when both occur in the same cycle (timed_out stays 0).
REQ-018 SHALL remain in DRAIN for exactly DRAIN_CYCLES cycles (0 = pass straight to DUMP_RD next cycle), ignoring inst inputs.
REQ-019 SHALL in DUMP_RD assert dump_rd_en=1 for one cycle with dump_addr=current index (starting 0), then go to DUMP_WAIT.
REQ-020 SHALL in DUMP_WAIT capture dump_rd_data into out_data, load out_index, set out_valid=1, go to DUMP_OUT.
REQ-021 SHALL in DUMP_OUT hold out_valid/out_index/out_data stable until out_ready=1; on acceptance clear out_valid and go to DUMP_RD with index+1, or FINISH if index==DUMP_WORDS-1.
REQ-022 SHALL permit at most one read outstanding; dump_rd_en=0 outside DUMP_RD.
REQ-023 SHALL in FINISH hold done=1, out_valid=0, all counters frozen, until reset.
REQ-024 SHALL drive running=1 only in RUN.

Reset
REQ-025 SHALL on reset=1 at posedge clk force RUN, cycle_count=0, index=0, drain count=0, timed_out=0, done=0, out_valid=0, dump_rd_en=0, dump_addr=0, out_index=0, out_data=0, from any state including mid-dump.
REQ-026 SHALL treat inst_valid as ignored during the reset cycle.

Configuration
REQ-027 SHALL compile timeout logic only when macro RUN_MONITOR_TIMEOUT_EN is defined; without it timed_out is tied 0 and RUN exits only on halt.

Structure
REQ-028 SHALL place FSM state enum and the state-encoding width constant in shared package run_monitor_pkg.
REQ-029 SHALL implement the dump sequencer (DUMP_RD/WAIT/OUT, index, output register) as sub-module run_monitor_dump, started by a one-cycle start pulse and returning a one-cycle last pulse.

Verification
REQ-030 Halt: HALT_INST fetched on 10th post-reset cycle -> cycle_count=9, running falls next cycle, DRAIN 5 cycles, timed_out=0.
REQ-031 Dump stream: DUMP_WORDS=20, memory word i = 0xA0000000+i, out_ready=1 -> 20 beats, indices 0..19, correct data, 3 cycles/beat, then done=1.
REQ-032 Backpressure: out_ready low 7 cycles on beat 4 -> out_valid/out_data/out_index stable, no extra dump_rd_en, no lost or duplicated beat.
REQ-033 Timeout (macro defined, TIMEOUT_CYCLES=100, no halt) -> timed_out=1 with cycle_count=100, dump still runs, done=1; same run without macro -> never leaves RUN.
REQ-034 Simultaneous: halt fetched when cycle_count==TIMEOUT_CYCLES -> timed_out=0, DRAIN entered.
REQ-035 Reset mid-dump at beat 7 -> next cycle all outputs at reset values, running=1, cycle_count=0; restarted run dumps from index 0.

Source files
------------

// File: rtl/run_monitor_pkg.sv
// run_monitor shared types: FSM state encodings and widths.
// Used by the top-level controller and the dump sequencer.
package run_monitor_pkg;

    localparam int STATE_W = 3;
    localparam int DRAIN_W = 8;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t S_RUN       = 3'd0;
    localparam state_t S_DRAIN     = 3'd1;
    localparam state_t S_DUMP_RD   = 3'd2;
    localparam state_t S_DUMP_WAIT = 3'd3;
    localparam state_t S_DUMP_OUT  = 3'd4;
    localparam state_t S_FINISH    = 3'd5;
    localparam state_t S_IDLE      = 3'd6;

endpackage

// File: rtl/run_monitor_if.sv
// run_monitor dump stream: valid/ready handshake carrying index and data.
// master drives the beat, slave returns ready.
interface run_monitor_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);
    logic                  out_valid;
    logic                  out_ready;
    logic [ADDR_WIDTH-1:0] out_index;
    logic [DATA_WIDTH-1:0] out_data;

    modport master (output out_valid, out_index, out_data, input out_ready);
    modport slave  (input out_valid, out_index, out_data, output out_ready);
endinterface

// File: rtl/run_monitor_dump.sv
// run_monitor dump sequencer: read word, register it, stream it out.
// Started by a one-cycle start pulse; pulses last when the final beat is taken.
module run_monitor_dump
    import run_monitor_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int DUMP_WORDS = 20
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  last,
    output logic                  dump_rd_en,
    output logic [ADDR_WIDTH-1:0] dump_addr,
    input  logic [DATA_WIDTH-1:0] dump_rd_data,
    run_monitor_if.master         out_if
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DUMP_WORDS - 1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic                  valid_q, valid_d;
    logic [ADDR_WIDTH-1:0] index_q, index_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    // Next-state: one read in flight, then hold the beat until accepted.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        index_d = index_q;
        data_d  = data_q;
        last    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_DUMP_RD;
            end
            S_DUMP_RD: begin
                state_d = S_DUMP_WAIT;
            end
            S_DUMP_WAIT: begin
                data_d  = dump_rd_data;
                index_d = idx_q;
                valid_d = 1'b1;
                state_d = S_DUMP_OUT;
            end
            S_DUMP_OUT: begin
                if (out_if.out_ready) begin
                    valid_d = 1'b0;
                    if (idx_q == LAST_IDX) begin
                        last    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_DUMP_RD;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sequencer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            valid_q <= 1'b0;
            index_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            index_q <= index_d;
            data_q  <= data_d;
        end
    end

    assign dump_rd_en       = (state_q == S_DUMP_RD);
    assign dump_addr        = idx_q;
    assign out_if.out_valid = valid_q;
    assign out_if.out_index = index_q;
    assign out_if.out_data  = data_q;

endmodule

// File: rtl/run_monitor.sv
// run_monitor top: counts run cycles, stops on halt (or timeout), drains, dumps.
// Timeout logic is built only when RUN_MONITOR_TIMEOUT_EN is defined.
module run_monitor
    import run_monitor_pkg::*;
#(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    ADDR_WIDTH     = 8,
    parameter int                    CNT_WIDTH      = 32,
    parameter logic [DATA_WIDTH-1:0] HALT_INST      = 32'h0,
    parameter int                    DRAIN_CYCLES   = 5,
    parameter int                    TIMEOUT_CYCLES = 1000000,
    parameter int                    DUMP_WORDS     = 20
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  inst_valid,
    input  logic [DATA_WIDTH-1:0] inst_from_imem,
    output logic                  dump_rd_en,
    output logic [ADDR_WIDTH-1:0] dump_addr,
    input  logic [DATA_WIDTH-1:0] dump_rd_data,
    run_monitor_if.master         out_if,
    output logic [CNT_WIDTH-1:0]  cycle_count,
    output logic                  running,
    output logic                  done,
    output logic                  timed_out
);

    localparam logic [DRAIN_W-1:0] DRAIN_LAST =
        DRAIN_W'((DRAIN_CYCLES == 0) ? 0 : DRAIN_CYCLES - 1);

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [DRAIN_W-1:0]   drain_q, drain_d;
    logic                 timed_q, timed_d;
    logic                 halt, tmo, start, last;

    assign halt = inst_valid && (inst_from_imem == HALT_INST);

`ifdef RUN_MONITOR_TIMEOUT_EN
    assign tmo = (cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES));
`else
    logic unused_timeout;
    assign unused_timeout = ^CNT_WIDTH'(TIMEOUT_CYCLES);
    assign tmo = 1'b0;
`endif

    // Controller: RUN counts, stop -> DRAIN -> dump phase -> FINISH.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        drain_d = drain_q;
        timed_d = timed_q;
        start   = 1'b0;
        unique case (state_q)
            S_RUN: begin
                if (halt || tmo) begin
                    timed_d = timed_q | (tmo & ~halt);
                    drain_d = '0;
                    if (DRAIN_CYCLES == 0) begin
                        start   = 1'b1;
                        state_d = S_DUMP_RD;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end else if (cnt_q != {CNT_WIDTH{1'b1}}) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    start   = 1'b1;
                    state_d = S_DUMP_RD;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            S_DUMP_RD: begin
                if (last) state_d = S_FINISH;
            end
            S_FINISH: state_d = S_FINISH;
            default:  state_d = S_RUN;
        endcase
    end

    // Controller registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
            drain_q <= '0;
            timed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drain_q <= drain_d;
            timed_q <= timed_d;
        end
    end

    run_monitor_dump #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DUMP_WORDS (DUMP_WORDS)
    ) u_dump (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .last         (last),
        .dump_rd_en   (dump_rd_en),
        .dump_addr    (dump_addr),
        .dump_rd_data (dump_rd_data),
        .out_if       (out_if)
    );

    assign cycle_count = cnt_q;
    assign running     = (state_q == S_RUN);
    assign done        = (state_q == S_FINISH);
    assign timed_out   = timed_q;

endmodule

// File: tb/tb_run_monitor.sv
// run_monitor bench: directed halt, dump, backpressure, mid-dump reset
// and timeout scenarios (timeout branch follows RUN_MONITOR_TIMEOUT_EN).
module tb_run_monitor;

    localparam int          DW   = 32;
    localparam int          AW   = 8;
    localparam int          CW   = 32;
    localparam int          NW   = 20;
    localparam int          TMO  = 100;
    localparam logic [31:0] HALT = 32'h0010_0073;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic          clk;
    logic          reset;
    logic          inst_valid;
    logic [DW-1:0] inst;
    logic          rd_en;
    logic [AW-1:0] addr;
    logic [DW-1:0] rd_data;
    logic [CW-1:0] cycle_count;
    logic          running;
    logic          done;
    logic          timed_out;

    int checks = 0;
    int errors = 0;

    run_monitor_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) oif ();

    run_monitor #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .CNT_WIDTH      (CW),
        .HALT_INST      (HALT),
        .DRAIN_CYCLES   (5),
        .TIMEOUT_CYCLES (TMO),
        .DUMP_WORDS     (NW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .inst_valid     (inst_valid),
        .inst_from_imem (inst),
        .dump_rd_en     (rd_en),
        .dump_addr      (addr),
        .dump_rd_data   (rd_data),
        .out_if         (oif),
        .cycle_count    (cycle_count),
        .running        (running),
        .done           (done),
        .timed_out      (timed_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Dump memory: word i holds 0xA0000000 + i, one-cycle read latency.
    always_ff @(posedge clk) begin
        if (rd_en) rd_data <= 32'hA000_0000 + 32'(addr);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string p);
        chk({p, "_running"}, 64'(running), 1);
        chk({p, "_count"}, 64'(cycle_count), 0);
        chk({p, "_done"}, 64'(done), 0);
        chk({p, "_timed_out"}, 64'(timed_out), 0);
        chk({p, "_out_valid"}, 64'(oif.out_valid), 0);
        chk({p, "_rd_en"}, 64'(rd_en), 0);
        chk({p, "_addr"}, 64'(addr), 0);
        chk({p, "_out_index"}, 64'(oif.out_index), 0);
        chk({p, "_out_data"}, 64'(oif.out_data), 0);
    endtask

    // Reset for one edge with a halt word presented; it must be ignored.
    task automatic do_reset(input string p);
        reset         = 1'b1;
        inst_valid    = 1'b1;
        inst          = HALT;
        oif.out_ready = 1'b1;
        tick();
        check_reset(p);
        reset = 1'b0;
        inst  = NOP;
    endtask

    // Halt on the 10th post-reset cycle, then walk the first 4 drain cycles.
    task automatic run_halt();
        repeat (9) tick();
        chk("pre_halt_count", 64'(cycle_count), 9);
        chk("pre_halt_running", 64'(running), 1);
        inst = HALT;
        tick();
        chk("halt_running", 64'(running), 0);
        chk("halt_count", 64'(cycle_count), 9);
        chk("halt_timed_out", 64'(timed_out), 0);
        chk("halt_rd_en", 64'(rd_en), 0);
        inst = NOP;
        repeat (4) begin
            tick();
            chk("drain_rd_en", 64'(rd_en), 0);
        end
    endtask

    task automatic run_dump(input int stall_beat, input int stall_len,
                            input int reset_beat);
        int beats;
        int rds;
        int t;
        int last_t;
        int left;
        bit held;
        bit fin;
        logic [DW-1:0] hd;
        logic [AW-1:0] hi;
        beats  = 0;
        rds    = 0;
        t      = 0;
        last_t = -1;
        left   = stall_len;
        held   = 1'b0;
        fin    = 1'b0;
        hd     = '0;
        hi     = '0;
        oif.out_ready = 1'b1;
        while (!fin && t < 600) begin
            tick();
            t++;
            if (rd_en) begin
                if (rds == 0) chk("drain_length", 64'(t), 1);
                chk("rd_addr", 64'(addr), 64'(rds));
                rds++;
            end
            chk("one_outstanding", 64'(rd_en & oif.out_valid), 0);
            if (oif.out_valid && beats == reset_beat) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
                return;
            end
            if (oif.out_valid && beats == stall_beat && left > 0) begin
                if (!held) begin
                    hd   = oif.out_data;
                    hi   = oif.out_index;
                    held = 1'b1;
                end else begin
                    chk("stall_data", 64'(oif.out_data), 64'(hd));
                    chk("stall_index", 64'(oif.out_index), 64'(hi));
                end
                oif.out_ready = 1'b0;
                left--;
            end else begin
                oif.out_ready = 1'b1;
            end
            if (oif.out_valid && oif.out_ready) begin
                chk("beat_index", 64'(oif.out_index), 64'(beats));
                chk("beat_data", 64'(oif.out_data),
                    64'(32'hA000_0000 + 32'(beats)));
                if (last_t >= 0)
                    chk("beat_spacing", 64'(t - last_t),
                        64'((beats == stall_beat) ? 3 + stall_len : 3));
                last_t = t;
                beats++;
            end
            if (done) fin = 1'b1;
        end
        chk("dump_done", 64'(done), 1);
        chk("dump_beats", 64'(beats), NW);
        chk("dump_reads", 64'(rds), NW);
        chk("dump_valid_low", 64'(oif.out_valid), 0);
    endtask

    initial begin
        reset         = 1'b1;
        inst_valid    = 1'b1;
        inst          = HALT;
        oif.out_ready = 1'b0;
        tick();
        do_reset("por");

        run_halt();
        run_dump(-1, 0, -1);
        repeat (3) tick();
        chk("finish_done", 64'(done), 1);
        chk("finish_count", 64'(cycle_count), 9);
        chk("finish_running", 64'(running), 0);
        chk("finish_rd_en", 64'(rd_en), 0);

        do_reset("rst2");
        run_halt();
        run_dump(4, 7, -1);

        do_reset("rst3");
        run_halt();
        run_dump(-1, 0, 7);
        check_reset("mid_dump");
        inst = NOP;
        run_halt();
        run_dump(-1, 0, -1);

`ifdef RUN_MONITOR_TIMEOUT_EN
        begin
            int n;
            n = 0;
            do_reset("tmo");
            while (running && n < 300) begin
                tick();
                n++;
            end
            chk("tmo_latency", 64'(n), TMO + 1);
            chk("tmo_flag", 64'(timed_out), 1);
            chk("tmo_count", 64'(cycle_count), TMO);
            repeat (4) tick();
            run_dump(-1, 0, -1);
            chk("tmo_sticky", 64'(timed_out), 1);

            do_reset("simul");
            repeat (TMO) tick();
            chk("simul_count", 64'(cycle_count), TMO);
            inst = HALT;
            tick();
            inst = NOP;
            chk("simul_running", 64'(running), 0);
            chk("simul_timed_out", 64'(timed_out), 0);
            chk("simul_count_hold", 64'(cycle_count), TMO);
        end
`else
        do_reset("notmo");
        repeat (150) tick();
        chk("notmo_running", 64'(running), 1);
        chk("notmo_timed_out", 64'(timed_out), 0);
        chk("notmo_count", 64'(cycle_count), 150);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
